// File: rtl/pipe_run_ctrl_if.sv
// Command handshake and trace readout bus between pipe_run_ctrl and the
// debug/bench harness.  The harness is the master: it issues commands and
// pops the trace; the controller is the slave.
interface pipe_run_ctrl_if #(
    parameter int CNT_W       = 17,
    parameter int STAGES      = 5,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16
);
    localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [CNT_W-1:0]           cmd_count;
    logic                       trace_rd;
    logic [STAGES*DATA_W-1:0]   trace_data;
    logic                       trace_empty;
    logic                       trace_full;
    logic [LVL_W-1:0]           trace_level;
    logic                       trace_ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_count, trace_rd,
        input  cmd_ready, trace_data, trace_empty, trace_full, trace_level, trace_ovf
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, trace_rd,
        output cmd_ready, trace_data, trace_empty, trace_full, trace_level, trace_ovf
    );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/halt controller and stage-trace recorder for the hybrid ARM/MIPS
// pipeline.  Drives the core halt in stop / free-run / run-N / single-step
// modes, counts executed cycles and captures the per-stage visibility words.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | core halted, commands accepted (unless trace full + stop-on-full)
// S_RUN   | free-running until stop_req or auto-halt on a full trace
// S_RUN_N | running for 'rem_q' more cycles, then back to idle with done
module pipe_run_ctrl #(
    parameter int CNT_W        = 17,
    parameter int STAGES       = 5,
    parameter int DATA_W       = 32,
    parameter int TRACE_DEPTH  = 16,
    parameter int STOP_ON_FULL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    pipe_run_ctrl_if.slave             bus,
    input  logic                       stop_req,
    output logic                       halt,
    input  logic [STAGES*DATA_W-1:0]   stage_data,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       done,
    output logic [1:0]                 state
);
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int W     = STAGES * DATA_W;
    localparam bit SOF   = (STOP_ON_FULL != 0);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_RUN_N = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_RUN_N = 2'b10
    } state_t;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_d;

    logic [LVL_W-1:0] wr_ptr, rd_ptr, level;
    logic [W-1:0]     mem [TRACE_DEPTH];
    logic             ovf_q;
    logic             full, empty, push, pop, rd_adv, cmd_fire, auto_halt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == LVL_W'(TRACE_DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign push      = !halt;
    assign pop       = bus.trace_rd && !empty;
    // A push into a full trace without a pop evicts the oldest entry.
    assign rd_adv    = pop || (push && full);
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign auto_halt = SOF && push && !pop && (level == LVL_W'(TRACE_DEPTH - 1));

    assign bus.cmd_ready   = (st_q == S_IDLE) && !(SOF && full);
    assign bus.trace_data  = mem[rd_ptr[PTR_W-1:0]];
    assign bus.trace_empty = empty;
    assign bus.trace_full  = full;
    assign bus.trace_level = level;
    assign bus.trace_ovf   = ovf_q;
    assign state           = st_q;

    // Next-state, run-length and done decode; stop_req outranks expiry and auto-halt.
    always_comb begin
        st_d   = st_q;
        rem_d  = rem_q;
        done_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_op)
                        OP_RUN:   st_d = S_RUN;
                        OP_RUN_N: begin
                            if (bus.cmd_count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                st_d  = S_RUN_N;
                                rem_d = bus.cmd_count;
                            end
                        end
                        OP_STEP: begin
                            st_d  = S_RUN_N;
                            rem_d = CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    st_d  = S_IDLE;
                    rem_d = '0;
                end else if (auto_halt) begin
                    st_d   = S_IDLE;
                    done_d = 1'b1;
                end
            end
            S_RUN_N: begin
                if (stop_req) begin
                    st_d  = S_IDLE;
                    rem_d = '0;
                end else if (rem_q == CNT_W'(1) || auto_halt) begin
                    st_d   = S_IDLE;
                    rem_d  = '0;
                    done_d = 1'b1;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: begin
                st_d  = S_IDLE;
                rem_d = '0;
            end
        endcase
    end

    // State, run-length, halt and done registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= S_IDLE;
            rem_q <= '0;
            halt  <= 1'b1;
            done  <= 1'b0;
        end else begin
            st_q  <= st_d;
            rem_q <= rem_d;
            halt  <= (st_d == S_IDLE);
            done  <= done_d;
        end
    end

    // Saturating count of executed (halt low) cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (push && cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // Trace pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + LVL_W'(1);
            if (rd_adv) rd_ptr <= rd_ptr + LVL_W'(1);
            if (!SOF && push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // Trace storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= stage_data;
    end
endmodule
